core7_led_driver: RTL
=====================

CORE7_LED_DRIVER -- requirements
Module: core7_led_driver

Interface
REQ-001 SHALL have parameter PRESCALE_RST, default 16'd0, reset value of the PRESCALE register.
REQ-002 SHALL have parameter DUTY_RST, default 8'hFF, reset value of the DUTY register.
REQ-003 clk  input  1  system clock; all state is on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 pattern  input  8  LED on/off pattern driven from the green-LED PIO out_port.
REQ-006 address  input  2  Avalon-MM slave word address.
REQ-007 chipselect  input  1  Avalon-MM slave select.
REQ-008 write_n  input  1  Avalon-MM write strobe, active-low.
REQ-009 writedata  input  32  Avalon-MM write data.
REQ-010 readdata  output  32  Avalon-MM read data, combinational, zero-wait-state.
REQ-011 led  output  8  physical LED drive, registered.

Function
REQ-012 SHALL decode a register write only when chipselect=1 and write_n=0, committing it on that clock edge.
REQ-013 SHALL implement register map: 0 CTRL{bit1 blink_en, bit0 enable}; 1 DUTY[7:0]; 2 BLINK[15:0]; 3 PRESCALE[15:0]; unused bits read 0 and ignore writes.
REQ-014 SHALL return the addressed register, zero-extended to 32 bits, on readdata every cycle, independent of chipselect.
REQ-015 SHALL register pattern once (pat_q) before use, giving a 2-cycle pattern-to-led latency.
REQ-016 SHALL run a 16-bit prescaler counting 0..PRESCALE and asserting a 1-cycle tick on the cycle it equals PRESCALE, then wrapping to 0; PRESCALE=0 gives tick every cycle.
REQ-017 SHALL clear the prescaler to 0 on any PRESCALE write, so a reduced PRESCALE never strands the count above it.
REQ-018 SHALL advance an 8-bit PWM counter on each tick, wrapping 255->0, and assert frame_end on the tick that wraps it.
REQ-019 SHALL define pwm_on = (DUTY==8'hFF) or (pwm_cnt < DUTY); DUTY=0 is fully off, DUTY=255 fully on.
REQ-020 SHALL run a 16-bit blink counter advancing on frame_end; when it equals BLINK it SHALL wrap to 0 and toggle blink_phase.
REQ-021 SHALL hold blink_phase at 1 and the blink counter at 0 while blink_en=0; setting blink_en starts from phase 1, count 0.
REQ-022 SHALL clear the blink counter on any BLINK write, keeping blink_phase.
REQ-023 SHALL compute led_next = enable ? (pat_q & {8{pwm_on & blink_phase}}) : 8'h00 and register it into led.
REQ-024 SHALL keep prescaler, PWM and blink counters running while enable=0 (enable gates output only).
REQ-025 SHALL treat a register write and a coincident tick/frame_end as: write takes effect, and the REQ-017/REQ-022 clears take priority over that cycle's increment.

Reset
REQ-026 SHALL on reset_n=0 set CTRL=0, DUTY=DUTY_RST, BLINK=0, PRESCALE=PRESCALE_RST, all counters 0, blink_phase=1, pat_q=0, led=0.
REQ-027 SHALL, on reset asserted mid-operation, force led=0 asynchronously and hold all state until reset_n deasserts.

Structure
REQ-028 SHALL place register addresses, CTRL bit positions and counter widths in a shared package core7_led_pkg.
REQ-029 SHALL implement prescaler + PWM counter + pwm_on as sub-module core7_led_pwm_gen; register file and blink logic stay in the top.

Verification
REQ-030 Reset, then CTRL=1, pattern=8'hA5, DUTY=255 -> led=8'hA5 two cycles after pattern changes, held constant.
REQ-031 PRESCALE=0, DUTY=64, CTRL=1, pattern=8'hFF -> led=8'hFF for exactly 64 of every 256 cycles, 8'h00 otherwise.
REQ-032 PRESCALE=0, DUTY=255, BLINK=1, CTRL=3, pattern=8'h0F -> led alternates 8'h0F/8'h00 every 512 cycles.
REQ-033 PRESCALE=9 then write PRESCALE=3 mid-count -> next tick exactly 4 cycles after the write; readdata at address 3 = 32'h3.
REQ-034 DUTY=0 with CTRL=1 -> led stays 8'h00 for 1024 cycles; then CTRL=0 with DUTY=255 -> led=8'h00.
REQ-035 Assert reset_n=0 while led=8'hFF and blink active -> led=8'h00 immediately; after release all registers read reset values.

Source files
------------

// File: rtl/core7_led_pkg.sv
// Shared definitions for the core7 LED driver: register map, CTRL bit
// positions and counter widths.
package core7_led_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 2;
  localparam int LED_W      = 8;
  localparam int PRESCALE_W = 16;
  localparam int PWM_W      = 8;
  localparam int BLINK_W    = 16;

  localparam logic [ADDR_W-1:0] ADDR_CTRL     = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_DUTY     = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_BLINK    = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_PRESCALE = 2'd3;

  localparam int CTRL_ENABLE_BIT   = 0;
  localparam int CTRL_BLINK_EN_BIT = 1;
  localparam int CTRL_W            = 2;

  // CTRL register layout; field order matches the bit positions above.
  typedef struct packed {
    logic blink_en;
    logic enable;
  } ctrl_t;

  // Zero-extend a 16-bit register value onto the read data bus.
  function automatic logic [DATA_W-1:0] zext16(input logic [15:0] v);
    return {{(DATA_W-16){1'b0}}, v};
  endfunction

endpackage

// File: rtl/core7_led_pwm_gen.sv
// Prescaler plus 8-bit PWM counter. Produces the per-frame wrap pulse and
// the pwm_on level for the current PWM slot.
module core7_led_pwm_gen
  import core7_led_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  prescale_clr,
  input  logic [PWM_W-1:0]      duty,
  output logic                  frame_end,
  output logic                  pwm_on
);

  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [PWM_W-1:0]      pwm_cnt_q, pwm_cnt_d;
  logic                  tick;

  assign tick      = (presc_q == prescale);
  assign frame_end = tick && (pwm_cnt_q == {PWM_W{1'b1}});
  assign pwm_on    = (duty == {PWM_W{1'b1}}) || (pwm_cnt_q < duty);

  // Next-state for the prescaler (clear wins over wrap/increment) and PWM slot.
  always_comb begin
    presc_d   = presc_q;
    pwm_cnt_d = pwm_cnt_q;
    if (prescale_clr) begin
      presc_d = '0;
    end else if (tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PRESCALE_W'(1);
    end
    if (tick) begin
      pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
    end
  end

  // Counter state, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
    end else begin
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

endmodule

// File: rtl/core7_led_driver.sv
// Avalon-MM controlled LED driver: registered pattern, PWM dimming and
// frame-based blinking, with a registered LED output.
module core7_led_driver
  import core7_led_pkg::*;
#(
  parameter logic [PRESCALE_W-1:0] PRESCALE_RST = 16'd0,
  parameter logic [PWM_W-1:0]      DUTY_RST     = 8'hFF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [LED_W-1:0]  pattern,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic [LED_W-1:0]  led
);

  ctrl_t                 ctrl_q, ctrl_d;
  logic [PWM_W-1:0]      duty_q, duty_d;
  logic [BLINK_W-1:0]    blink_q, blink_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic [LED_W-1:0]      pat_q, pat_d;
  logic [LED_W-1:0]      led_q, led_d;

  logic wr_en;
  logic prescale_wr;
  logic blink_wr;
  logic frame_end;
  logic pwm_on;

  // Upper write-data bits have no register behind them.
  logic unused_wdata;
  assign unused_wdata = ^writedata[DATA_W-1:PRESCALE_W];

  assign wr_en       = chipselect && !write_n;
  assign prescale_wr = wr_en && (address == ADDR_PRESCALE);
  assign blink_wr    = wr_en && (address == ADDR_BLINK);
  assign led         = led_q;

  core7_led_pwm_gen u_pwm_gen (
    .clk          (clk),
    .reset_n      (reset_n),
    .prescale     (prescale_q),
    .prescale_clr (prescale_wr),
    .duty         (duty_q),
    .frame_end    (frame_end),
    .pwm_on       (pwm_on)
  );

  // Zero-wait-state read mux, driven regardless of chipselect.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL:     readdata = {{(DATA_W-CTRL_W){1'b0}}, ctrl_q};
      ADDR_DUTY:     readdata = {{(DATA_W-PWM_W){1'b0}}, duty_q};
      ADDR_BLINK:    readdata = zext16(blink_q);
      ADDR_PRESCALE: readdata = zext16(prescale_q);
      default:       readdata = '0;
    endcase
  end

  // Register writes, blink sequencing and the next LED value.
  always_comb begin
    ctrl_d        = ctrl_q;
    duty_d        = duty_q;
    blink_d       = blink_q;
    prescale_d    = prescale_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    pat_d         = pattern;
    led_d         = '0;

    if (wr_en) begin
      case (address)
        ADDR_CTRL: begin
          ctrl_d.enable   = writedata[CTRL_ENABLE_BIT];
          ctrl_d.blink_en = writedata[CTRL_BLINK_EN_BIT];
        end
        ADDR_DUTY:     duty_d     = writedata[PWM_W-1:0];
        ADDR_BLINK:    blink_d    = writedata[BLINK_W-1:0];
        ADDR_PRESCALE: prescale_d = writedata[PRESCALE_W-1:0];
        default:       ;
      endcase
    end

    // Blink disabled parks the sequencer so enabling starts visibly "on".
    // A BLINK write restarts the count but leaves the current phase alone.
    if (!ctrl_q.blink_en) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b1;
    end else if (blink_wr) begin
      blink_cnt_d = '0;
    end else if (frame_end) begin
      if (blink_cnt_q == blink_q) begin
        blink_cnt_d   = '0;
        blink_phase_d = !blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end

    if (ctrl_q.enable) begin
      led_d = pat_q & {LED_W{pwm_on && blink_phase_q}};
    end
  end

  // All top-level state; reset drives the LEDs dark immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q        <= '0;
      duty_q        <= DUTY_RST;
      blink_q       <= '0;
      prescale_q    <= PRESCALE_RST;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      pat_q         <= '0;
      led_q         <= '0;
    end else begin
      ctrl_q        <= ctrl_d;
      duty_q        <= duty_d;
      blink_q       <= blink_d;
      prescale_q    <= prescale_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      pat_q         <= pat_d;
      led_q         <= led_d;
    end
  end

endmodule
